clk_enable_gen: RTL and testbench
=================================

# clk_enable_gen

Parametrised multi-channel clock/tick generator, the successor to the fixed two-output divider. It produces NUM_CH independent divided clock levels plus single-cycle tick enables from one system clock. Each channel's half-period is programmable at run time with glitch-free (boundary-aligned) updates, plus per-channel enable and a global phase-align clear. It feeds blink/timer logic in the parking controller, which should use `tick` as a clock enable rather than clocking logic from `clk_out`.

## Interface
- NUM_CH, 2: number of output channels (1..16).
- CNT_W, 26: width of counters and half-period values.
- RESET_HALF, {26'd10_000_000, 26'd20_000_000}: packed NUM_CH*CNT_W reset half-periods, channel 0 in the LSBs (1 Hz / 2 Hz at 40 MHz).
- CH_W, derived: max(1, $clog2(NUM_CH)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- cfg_wr  in  1  one-cycle write strobe for a half-period.
- cfg_ch  in  CH_W  target channel; values >= NUM_CH ignored.
- cfg_half  in  CNT_W  new half-period in clk cycles.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_clr  in  1  synchronous clear of all channel phases.
- clk_out  out  NUM_CH  divided clock level per channel.
- tick  out  NUM_CH  one-cycle pulse when clk_out rises.
- cfg_pending  out  NUM_CH  staged half-period not yet applied.

## Operation
- Per channel: counter cnt, active half-period act, staged value stg, pending flag.
- Reset (async, reset=0): cnt=0, act=stg=RESET_HALF slice, pending=0, clk_out=0, tick=0.
- Counting, when ch_en=1 and act!=0: terminal = (cnt >= act-1). On terminal: cnt<=0, clk_out toggles; otherwise cnt increments. The `>=` compare absorbs any shrink of act.
- act=0: channel holds. cnt and clk_out are frozen, tick=0.
- ch_en=0: cnt and clk_out are frozen (the level holds), tick=0.
- Write: cfg_wr with valid cfg_ch sets stg<=cfg_half and pending<=1. A second write while pending overwrites stg, last write wins.
- Apply (act<=stg, pending<=0) happens on that channel's terminal cycle, at the same edge as the toggle. The new value governs the next half-period.
- Apply is immediate (next edge) if the channel is disabled, or if act=0.
- sync_clr: all channels get cnt<=0 and clk_out<=0, tick<=0, and every pending stg is applied. It overrides counting and terminal logic in that cycle. A cfg_wr in the same cycle is applied immediately (act<=cfg_half) for its channel.
- cfg_wr coinciding with the target's terminal cycle: the old stg (if pending) is applied, the new value is staged, and pending stays 1.
- tick[i] is registered. It is 1 for exactly the cycle after a 0->1 toggle edge, i.e. during the first clk cycle of clk_out[i] high. Falling edges produce no tick.

## Timing
- Output period = 2*act cycles, 50% duty, for act>=1. act=1 gives clk/2 with tick every other cycle.
- After reset release with ch_en=1: clk_out rises at the act-th rising clk edge; the first tick is high in the following cycle.
- After sync_clr (edge E): rising edge at E+act, falling edge at E+2*act.
- Half-period changes never produce a short or long half-cycle other than the old value followed by the new one.
- Write-to-effect latency: at most the remaining cycles of the current half-period, plus 1.
- All outputs come directly from flops. No combinational path from inputs to outputs.

## Test plan
- Reset/defaults: hold reset=0 for 5 cycles with NUM_CH=2, RESET_HALF={3,5}, ch_en=11 -> all outputs 0 during reset. After release, ch0 rises at edge 5 and ch1 at edge 3, with periods 10 and 6. tick is one cycle wide at each rise.
- Run-time change: ch0 act=5. Write cfg_half=2 at cnt=1 -> cfg_pending[0]=1. The current half runs its full 5 cycles, then half-periods are 2. pending clears at the toggle edge. A second write of 4 before the boundary wins, giving 4.
- Hold/disable: write act=0 while ch0 is disabled -> applied next edge, clk_out frozen at its level, tick stays 0. Drop ch_en[1] mid-half at cnt=2 -> level frozen. Re-enabling resumes from cnt=2.
- Phase align: channels at arbitrary phase, pulse sync_clr -> both clk_out=0 and cnt=0. Pending values are applied. Rises occur at E+act[i], and equal act values give identical waveforms.
- Reset mid-operation: assert reset asynchronously (not edge-aligned) while clk_out=1 with a write pending -> outputs go 0 immediately, pending clears, act returns to RESET_HALF.
- Edge cases: act=1 gives a toggle every cycle with tick every 2 cycles. cfg_ch=NUM_CH has no effect. act=2^CNT_W-1 reaches terminal with no counter overflow.

Source files
------------

// File: rtl/clk_enable_gen.sv
// Multi-channel clock divider. Each channel emits a 50% duty level, a one-cycle tick on its
// rising edge, and takes run-time half-period updates that land on the channel's own boundary.
module clk_enable_gen #(
  parameter int                        NUM_CH     = 2,
  parameter int                        CNT_W      = 26,
  parameter logic [NUM_CH*CNT_W-1:0]   RESET_HALF = {26'd10_000_000, 26'd20_000_000},
  localparam int                       CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] stg_q, stg_d;
    logic             pend_q, pend_d;
    logic             lvl_q, lvl_d;
    logic             tick_q, tick_d;
    logic             wr_hit_s;
    logic             run_s;
    logic             term_s;

    // Out-of-range channel numbers never match any index, so they fall through as no-ops.
    assign wr_hit_s = cfg_wr && (cfg_ch == CH_W'(i));
    assign run_s    = ch_en[i] && (act_q != {CNT_W{1'b0}});
    assign term_s   = run_s && (cnt_q >= (act_q - CNT_W'(1)));

    // Next-state: phase clear beats counting; a write in a terminal cycle re-stages after the apply.
    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      stg_d  = stg_q;
      pend_d = pend_q;
      lvl_d  = lvl_q;
      tick_d = 1'b0;
      if (sync_clr) begin
        cnt_d = {CNT_W{1'b0}};
        lvl_d = 1'b0;
        if (wr_hit_s) begin
          act_d  = cfg_half;
          stg_d  = cfg_half;
          pend_d = 1'b0;
        end else if (pend_q) begin
          act_d  = stg_q;
          pend_d = 1'b0;
        end else begin
          act_d  = act_q;
        end
      end else begin
        if (term_s) begin
          cnt_d  = {CNT_W{1'b0}};
          lvl_d  = ~lvl_q;
          tick_d = ~lvl_q;
        end else if (run_s) begin
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          cnt_d  = cnt_q;
        end
        // A stopped or idle channel has no boundary to wait for, so it takes the value at once.
        if (pend_q && (term_s || !run_s)) begin
          act_d  = stg_q;
          pend_d = 1'b0;
        end else begin
          act_d  = act_q;
        end
        if (wr_hit_s) begin
          stg_d  = cfg_half;
          pend_d = 1'b1;
        end else begin
          stg_d  = stg_q;
        end
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q  <= {CNT_W{1'b0}};
        act_q  <= RESET_HALF[i*CNT_W +: CNT_W];
        stg_q  <= RESET_HALF[i*CNT_W +: CNT_W];
        pend_q <= 1'b0;
        lvl_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        stg_q  <= stg_d;
        pend_q <= pend_d;
        lvl_q  <= lvl_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[i]     = lvl_q;
    assign tick[i]        = tick_q;
    assign cfg_pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: reset table, directed corner sequences and
// randomized traffic checked against a cycle-level reference model of the channel rules.
module tb_clk_enable_gen;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam logic [NUM_CH*CNT_W-1:0] RH = {8'd4, 8'd3, 8'd5};

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] exp_out;
    logic [NUM_CH-1:0] exp_tick;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_clr;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  int checks = 0;
  int errors = 0;

  int m_el[NUM_CH];
  int m_half[NUM_CH];
  int m_stg[NUM_CH];
  bit m_lvl[NUM_CH];
  bit m_tick[NUM_CH];
  bit m_pend[NUM_CH];

  vec_t tbl[12];

  always #5 clk = ~clk;

  clk_enable_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_HALF(RH)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_half(cfg_half),
    .ch_en(ch_en), .sync_clr(sync_clr), .clk_out(clk_out), .tick(tick),
    .cfg_pending(cfg_pending)
  );

  function automatic int reset_half(int ch);
    logic [NUM_CH*CNT_W-1:0] v;
    v = RH;
    return int'(v[ch*CNT_W +: CNT_W]);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_el[i] = 0; m_half[i] = reset_half(i); m_stg[i] = m_half[i];
      m_lvl[i] = 1'b0; m_tick[i] = 1'b0; m_pend[i] = 1'b0;
    end
  endfunction

  // One clock of the channel rules, using the inputs presented before the edge.
  function automatic void m_step();
    for (int i = 0; i < NUM_CH; i++) begin
      bit wr, live, done;
      wr = cfg_wr && (int'(cfg_ch) == i);
      if (sync_clr) begin
        m_el[i] = 0; m_lvl[i] = 1'b0; m_tick[i] = 1'b0;
        if (wr) begin
          m_half[i] = int'(cfg_half); m_stg[i] = m_half[i]; m_pend[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_half[i] = m_stg[i]; m_pend[i] = 1'b0;
        end
      end else begin
        live = ch_en[i] && (m_half[i] > 0);
        done = live && (m_el[i] + 1 >= m_half[i]);
        m_tick[i] = done && !m_lvl[i];
        if (done) begin
          m_lvl[i] = !m_lvl[i]; m_el[i] = 0;
        end else if (live) begin
          m_el[i] = m_el[i] + 1;
        end
        if (m_pend[i] && (done || !live)) begin
          m_half[i] = m_stg[i]; m_pend[i] = 1'b0;
        end
        if (wr) begin
          m_stg[i] = int'(cfg_half); m_pend[i] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [NUM_CH-1:0] mvec(int kind);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = (kind == 0) ? m_lvl[i] : (kind == 1) ? m_tick[i] : m_pend[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) m_step(); else m_reset();
    @(negedge clk);
    chk("clk_out", clk_out, mvec(0));
    chk("tick", tick, mvec(1));
    chk("cfg_pending", cfg_pending, mvec(2));
  endtask

  task automatic write(input int ch, input int half);
    cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_half = CNT_W'(half);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic sync(input bit with_wr, input int ch, input int half);
    sync_clr = 1'b1; cfg_wr = with_wr; cfg_ch = CH_W'(ch); cfg_half = CNT_W'(half);
    step();
    sync_clr = 1'b0; cfg_wr = 1'b0;
  endtask

  // Cycles until the channel level next changes; 600 marks an expired bound.
  task automatic wait_toggle(input int ch, output int n);
    logic prev;
    prev = clk_out[ch];
    n = 0;
    while (n < 600) begin
      step();
      n++;
      if (clk_out[ch] !== prev) break;
    end
  endtask

  initial begin
    int n;
    tbl[0]  = '{3'b111, 3'b000, 3'b000};
    tbl[1]  = '{3'b111, 3'b000, 3'b000};
    tbl[2]  = '{3'b111, 3'b010, 3'b010};
    tbl[3]  = '{3'b111, 3'b110, 3'b100};
    tbl[4]  = '{3'b111, 3'b111, 3'b001};
    tbl[5]  = '{3'b111, 3'b101, 3'b000};
    tbl[6]  = '{3'b111, 3'b101, 3'b000};
    tbl[7]  = '{3'b111, 3'b001, 3'b000};
    tbl[8]  = '{3'b111, 3'b011, 3'b010};
    tbl[9]  = '{3'b111, 3'b010, 3'b000};
    tbl[10] = '{3'b111, 3'b010, 3'b000};
    tbl[11] = '{3'b111, 3'b100, 3'b100};

    reset = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_half = '0; ch_en = 3'b111; sync_clr = 1'b0;
    m_reset();
    repeat (5) step();
    reset = 1'b1;

    // Free run from reset against hand-derived waveforms.
    for (int k = 0; k < 12; k++) begin
      ch_en = tbl[k].en;
      step();
      chk("tbl_out", clk_out, tbl[k].exp_out);
      chk("tbl_tick", tick, tbl[k].exp_tick);
    end

    // Run-time change: current half of 5 completes, second staged write wins.
    sync(1'b0, 0, 0);
    step();
    write(0, 2);
    chk_int("pend_after_wr", int'(cfg_pending[0]), 1);
    write(0, 4);
    wait_toggle(0, n); chk_int("rest_of_old_half", n, 2);
    chk_int("pend_cleared", int'(cfg_pending[0]), 0);
    wait_toggle(0, n); chk_int("new_half_a", n, 4);
    wait_toggle(0, n); chk_int("new_half_b", n, 4);

    // Disabled channel takes a write at once; act=0 holds the level.
    ch_en = 3'b110;
    write(0, 0);
    step();
    chk_int("disabled_apply", int'(cfg_pending[0]), 0);
    repeat (8) step();
    ch_en = 3'b111;
    repeat (8) step();
    write(0, 3);
    repeat (10) step();

    // Freeze ch1 at cnt=2, then resume into its terminal cycle.
    sync(1'b0, 0, 0);
    step(); step();
    ch_en = 3'b101;
    repeat (5) step();
    chk_int("frozen_level", int'(clk_out[1]), 0);
    ch_en = 3'b111;
    wait_toggle(1, n); chk_int("resume_cnt2", n, 1);

    // Phase align with a staged value and a same-cycle write.
    repeat (3) step();
    write(2, 6);
    sync(1'b1, 1, 6);
    chk("sync_out", clk_out, 3'b000);
    chk("sync_pend", cfg_pending, 3'b000);
    wait_toggle(1, n); chk_int("sync_rise_ch1", n, 6);
    chk_int("sync_rise_ch2", int'(clk_out[2]), 1);
    wait_toggle(1, n); chk_int("sync_fall_ch1", n, 6);

    // act=1, invalid channel, and full-scale half-period.
    sync(1'b1, 0, 1);
    wait_toggle(0, n); chk_int("act1_a", n, 1);
    wait_toggle(0, n); chk_int("act1_b", n, 1);
    write(3, 9);
    chk("bad_ch_pend", cfg_pending, 3'b000);
    wait_toggle(0, n); chk_int("bad_ch_no_effect", n, 1);
    sync(1'b1, 0, 255);
    wait_toggle(0, n); chk_int("max_half_a", n, 255);
    wait_toggle(0, n); chk_int("max_half_b", n, 255);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      ch_en    = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom) : 3'b111;
      cfg_wr   = ($urandom_range(0, 7) == 0);
      cfg_ch   = CH_W'($urandom_range(0, 3));
      cfg_half = CNT_W'($urandom_range(0, 6));
      sync_clr = ($urandom_range(0, 49) == 0);
      step();
    end
    cfg_wr = 1'b0; sync_clr = 1'b0; ch_en = 3'b111;

    // Asynchronous reset while high with a write pending.
    sync(1'b1, 0, 4);
    n = 0;
    while (clk_out[0] !== 1'b1 && n < 50) begin step(); n++; end
    write(0, 7);
    chk_int("pre_rst_level", int'(clk_out[0]), 1);
    chk_int("pre_rst_pend", int'(cfg_pending[0]), 1);
    @(posedge clk);
    m_step();
    #3;
    reset = 1'b0;
    #1;
    chk("arst_out", clk_out, 3'b000);
    chk("arst_tick", tick, 3'b000);
    chk("arst_pend", cfg_pending, 3'b000);
    m_reset();
    @(negedge clk);
    repeat (3) step();
    reset = 1'b1;
    wait_toggle(0, n); chk_int("reset_half_restored", n, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
